// File: rtl/rx_serial_comando.sv
// rtl/rx_serial_comando.sv - 7O1 UART command receiver decoding 'I'/'A'/'F' into control pulses
module rx_serial_comando #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [6:0] dado,
  output logic       pronto,
  output logic       erro_paridade,
  output logic       erro_quadro,
  output logic       cmd_iniciar,
  output logic       cmd_abre,
  output logic       cmd_fecha,
  output logic [3:0] db_estado
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [2:0] {
    INICIAL  = 3'd0,
    ESPERA   = 3'd1,
    START    = 3'd2,
    DADOS    = 3'd3,
    PARIDADE = 3'd4,
    STOP     = 3'd5,
    FIM      = 3'd6,
    QUEBRA   = 3'd7
  } estado_t;

  estado_t       estado;
  estado_t       prox;
  logic          rx_m;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    nbit;
  logic [6:0]    shreg;
  logic          par_s;
  logic          stop_s;
  logic          tick;
  logic          ep_calc;
  logic          eq_calc;
  logic          valido;

  // The start bit is sampled at its middle; every later bit one full bit period after the previous sample
  assign tick = (estado == START) ? (cnt == CW'(HALF_BIT)) : (cnt == CW'(CLKS_PER_BIT - 1));

  // Odd parity over data plus parity bit; stop bit must be high
  assign ep_calc   = ~(^shreg ^ par_s);
  assign eq_calc   = ~stop_s;
  assign valido    = ~ep_calc & ~eq_calc;
  assign db_estado = {1'b0, estado};

  // Two-flop synchronizer for the asynchronous RX line, idle high
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= entrada_serial;
      rx_s <= rx_m;
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= prox;
  end

  // Next state and single-cycle pulses issued in FIM
  always_comb begin
    prox        = estado;
    pronto      = 1'b0;
    cmd_iniciar = 1'b0;
    cmd_abre    = 1'b0;
    cmd_fecha   = 1'b0;
    case (estado)
      INICIAL:  prox = ESPERA;
      ESPERA:   if (!rx_s) prox = START;
      START:    if (tick) prox = rx_s ? ESPERA : DADOS;
      DADOS:    if (tick && nbit == 3'd6) prox = PARIDADE;
      PARIDADE: if (tick) prox = STOP;
      STOP:     if (tick) prox = FIM;
      FIM: begin
        pronto      = 1'b1;
        cmd_iniciar = valido && (shreg == 7'h49);
        cmd_abre    = valido && (shreg == 7'h41);
        cmd_fecha   = valido && (shreg == 7'h46);
        // A line still low after the stop slot is a break, not a new start bit
        prox        = rx_s ? ESPERA : QUEBRA;
      end
      QUEBRA:   if (rx_s) prox = ESPERA;
      default:  prox = INICIAL;
    endcase
  end

  // Bit timer, bit counter and sample capture
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      nbit   <= 3'd0;
      shreg  <= 7'd0;
      par_s  <= 1'b0;
      stop_s <= 1'b0;
    end else begin
      case (estado)
        START, DADOS, PARIDADE, STOP: cnt <= tick ? '0 : cnt + CW'(1);
        default:                      cnt <= '0;
      endcase
      if (estado == START && tick) nbit <= 3'd0;
      if (estado == DADOS && tick) begin
        nbit  <= nbit + 3'd1;
        shreg <= {rx_s, shreg[6:1]};
      end
      if (estado == PARIDADE && tick) par_s <= rx_s;
      if (estado == STOP && tick) stop_s <= rx_s;
    end
  end

  // Character and error flags load together at the end of every frame, valid or not
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dado          <= 7'd0;
      erro_paridade <= 1'b0;
      erro_quadro   <= 1'b0;
    end else if (estado == FIM) begin
      dado          <= shreg;
      erro_paridade <= ep_calc;
      erro_quadro   <= eq_calc;
    end
  end

endmodule

// File: tb/tb_rx_serial_comando.sv
// tb/tb_rx_serial_comando.sv - directed self-checking bench for rx_serial_comando
module tb_rx_serial_comando;

  localparam int CPB = 434;
  localparam int H   = 217;
  // Line edge captured at posedge E is expected to produce pronto in cycle E+LAT
  localparam int LAT = 3 + H + 9 * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       entrada_serial = 1'b1;
  logic [6:0] dado;
  logic       pronto;
  logic       erro_paridade;
  logic       erro_quadro;
  logic       cmd_iniciar;
  logic       cmd_abre;
  logic       cmd_fecha;
  logic [3:0] db_estado;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic chk_en = 1'b0;

  logic [6:0] m_dado = 7'd0;
  logic       m_ep = 1'b0;
  logic       m_eq = 1'b0;
  logic       pend = 1'b0;
  int         pend_cyc = 0;
  logic [2:0] pend_cmd = 3'd0;
  logic [6:0] pend_dado = 7'd0;
  logic       pend_ep = 1'b0;
  logic       pend_eq = 1'b0;
  int n_pronto = 0;
  int n_ini = 0;
  int n_abre = 0;
  int n_fecha = 0;

  rx_serial_comando dut (
    .clock         (clock),
    .reset         (reset),
    .entrada_serial(entrada_serial),
    .dado          (dado),
    .pronto        (pronto),
    .erro_paridade (erro_paridade),
    .erro_quadro   (erro_quadro),
    .cmd_iniciar   (cmd_iniciar),
    .cmd_abre      (cmd_abre),
    .cmd_fecha     (cmd_fecha),
    .db_estado     (db_estado)
  );

  always #10 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Every cycle: registered outputs against the model, pulses against the pending frame
  always @(negedge clock) begin
    if (chk_en) begin
      if (!reset) begin
        m_dado = 7'd0;
        m_ep   = 1'b0;
        m_eq   = 1'b0;
        pend   = 1'b0;
      end
      check("dado", dado, m_dado);
      check("erro_paridade", erro_paridade, m_ep);
      check("erro_quadro", erro_quadro, m_eq);
      if (pronto) begin
        n_pronto++;
        check("pronto_expected", pend, 1);
        if (pend) begin
          check("pronto_timing", int'(cyc >= pend_cyc - 1 && cyc <= pend_cyc + 1), 1);
          check("cmd_pulse", {cmd_iniciar, cmd_abre, cmd_fecha}, pend_cmd);
          m_dado = pend_dado;
          m_ep   = pend_ep;
          m_eq   = pend_eq;
          pend   = 1'b0;
        end
      end else begin
        check("cmd_idle", {cmd_iniciar, cmd_abre, cmd_fecha}, 0);
        if (pend && cyc > pend_cyc + 1) begin
          check("pronto_deadline", pronto, 1);
          pend = 1'b0;
        end
      end
      n_ini   += int'(cmd_iniciar);
      n_abre  += int'(cmd_abre);
      n_fecha += int'(cmd_fecha);
    end
  end

  // Called at a negedge; drives start, 7 data LSB first, parity, stop; leaves line at stop level
  task automatic send_frame(input logic [6:0] d, input logic par, input logic stp, input int bclk);
    logic [9:0] bits;
    pend_dado = d;
    pend_ep   = ($countones({d, par}) % 2) == 0;
    pend_eq   = !stp;
    if (!pend_ep && !pend_eq)
      pend_cmd = (d == 7'h49) ? 3'b100 : (d == 7'h41) ? 3'b010 : (d == 7'h46) ? 3'b001 : 3'b000;
    else
      pend_cmd = 3'b000;
    pend_cyc = cyc + 1 + LAT;
    pend     = 1'b1;
    bits = {stp, par, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      entrada_serial = bits[i];
      repeat (bclk) @(negedge clock);
    end
  endtask

  initial begin
    #(20 * 100000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] a_char;
    a_char = 7'h41;
    reset = 1'b0;
    entrada_serial = 1'b1;
    repeat (3) @(negedge clock);
    chk_en = 1'b1;
    check("rst_dado", dado, 0);
    check("rst_pronto", pronto, 0);
    check("rst_estado", db_estado, 0);
    reset = 1'b1;
    @(negedge clock);
    check("estado_espera", db_estado, 1);
    repeat (20) @(negedge clock);

    // 'I' nominal
    send_frame(7'h49, 1'b0, 1'b1, CPB);
    repeat (20) @(negedge clock);
    check("I_dado", dado, 7'h49);
    check("I_ep", erro_paridade, 0);
    check("I_eq", erro_quadro, 0);
    check("I_cmd_count", n_ini, 1);
    check("I_pronto_count", n_pronto, 1);

    // 'A' then 'F' back-to-back
    send_frame(7'h41, 1'b1, 1'b1, CPB);
    send_frame(7'h46, 1'b0, 1'b1, CPB);
    repeat (20) @(negedge clock);
    check("AF_abre_count", n_abre, 1);
    check("AF_fecha_count", n_fecha, 1);
    check("AF_dado", dado, 7'h46);

    // 'A' with wrong parity
    send_frame(7'h41, 1'b0, 1'b1, CPB);
    repeat (20) @(negedge clock);
    check("Apar_ep", erro_paridade, 1);
    check("Apar_eq", erro_quadro, 0);
    check("Apar_dado", dado, 7'h41);
    check("Apar_abre_count", n_abre, 1);
    check("Apar_pronto_count", n_pronto, 4);

    // 'I' with stop bit 0, line held low
    send_frame(7'h49, 1'b0, 1'b0, CPB);
    repeat (3 * CPB) @(negedge clock);
    check("brk_eq", erro_quadro, 1);
    check("brk_ini_count", n_ini, 1);
    check("brk_estado", db_estado, 7);
    entrada_serial = 1'b1;
    repeat (5) @(negedge clock);
    check("brk_release_estado", db_estado, 1);
    repeat (20) @(negedge clock);
    send_frame(7'h46, 1'b0, 1'b1, CPB);
    repeat (20) @(negedge clock);
    check("brkF_dado", dado, 7'h46);
    check("brkF_fecha_count", n_fecha, 2);
    check("brkF_eq", erro_quadro, 0);

    // Glitch low for 100 cycles
    entrada_serial = 1'b0;
    repeat (100) @(negedge clock);
    entrada_serial = 1'b1;
    repeat (400) @(negedge clock);
    check("glitch_estado", db_estado, 1);
    check("glitch_pronto_count", n_pronto, 6);
    check("glitch_dado", dado, 7'h46);

    // Reset in the middle of the data bits of 'A'
    entrada_serial = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      entrada_serial = a_char[i];
      repeat (CPB) @(negedge clock);
    end
    #3;
    reset = 1'b0;
    #1;
    check("midrst_dado", dado, 0);
    check("midrst_pronto", pronto, 0);
    check("midrst_eq", erro_quadro, 0);
    check("midrst_cmds", {cmd_iniciar, cmd_abre, cmd_fecha}, 0);
    check("midrst_estado", db_estado, 0);
    entrada_serial = 1'b1;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    check("postrst_estado", db_estado, 1);
    send_frame(7'h41, 1'b1, 1'b1, CPB);
    repeat (20) @(negedge clock);
    check("postrst_abre_count", n_abre, 2);
    check("postrst_dado", dado, 7'h41);

    // 'Z' with the sender 2% fast
    send_frame(7'h5A, 1'b1, 1'b1, 425);
    repeat (20) @(negedge clock);
    check("Z_dado", dado, 7'h5A);
    check("Z_ep", erro_paridade, 0);
    check("Z_pronto_count", n_pronto, 8);
    check("Z_cmd_counts", n_ini + n_abre + n_fecha, 5);

    // 'I' with the sender 2% slow
    send_frame(7'h49, 1'b0, 1'b1, 443);
    repeat (20) @(negedge clock);
    check("Islow_ini_count", n_ini, 2);
    check("Islow_dado", dado, 7'h49);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
